// File: rtl/sync_debouncer_if.sv
// Level-conditioning bundle: raw input toward the debouncer, clean level and qualify flag back.
// No timing of its own; carries plain wires between producer and consumer.
// No flow control; the level is sampled every clock.
interface sync_debouncer_if;
  logic a;     // raw asynchronous level
  logic y;     // debounced synchronous level
  logic busy;  // a candidate change is being qualified

  // Side that owns the raw level and observes the conditioned result
  modport master (
    output a,
    input  y,
    input  busy
  );

  // Side that conditions the level (the debouncer itself)
  modport slave (
    input  a,
    output y,
    output busy
  );
endinterface

// File: rtl/sync_debouncer.sv
// Synchronizes a raw asynchronous level and only passes a change once it has held steady.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a stable new input to y.
// No backpressure; the input is a level and is sampled on every rising edge.
module sync_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  sync_debouncer_if.slave bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice; keep
  // at least one bit so the single-cycle configuration still elaborates.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  // Synchronizer chain; index 0 takes the raw input, the top index is s.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             busy_q;

  // Plain flop chain with nothing between stages so metastability can settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce state, counter and output level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      y_q     <= RESET_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= (state_d == COUNT);
    end
  end

  // Qualify a candidate change: any sample matching y aborts it and discards
  // all progress; the last differing sample commits it and returns to STABLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    if (s == y_q) begin
      cnt_d   = '0;
      state_d = STABLE;
    end else if (cnt_q == CNT_LAST) begin
      y_d     = s;
      cnt_d   = '0;
      state_d = STABLE;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = COUNT;
    end
  end

  // Both outputs come straight from flops; busy mirrors the COUNT state.
  assign bus.y    = y_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sync_debouncer.sv
module tb_sync_debouncer;

  logic clk;
  logic rst;
  logic rst1;
  int   vectors;
  int   miscompares;

  sync_debouncer_if bus ();
  sync_debouncer_if bus1 ();

  sync_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  sync_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(1),
    .RESET_LEVEL(1'b1)
  ) dut1 (
    .clk(clk),
    .rst(rst1),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (bus.y !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_y got=%b exp=0", bus.y);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    vectors++;
    if (bus1.y !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_y_lvl1 got=%b exp=1", bus1.y);
    end
    vectors++;
    if (bus1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_lvl1 got=%b exp=0", bus1.busy);
    end
    tick();
    tick();
  endtask

  task automatic test_clean_rise();
    rst   = 1'b0;
    bus.a = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (bus.y !== (e >= 6)) begin
        miscompares++;
        $display("FAIL rise_y edge=%0d got=%b exp=%b", e, bus.y, (e >= 6));
      end
      vectors++;
      if (bus.busy !== (e >= 3 && e <= 5)) begin
        miscompares++;
        $display("FAIL rise_busy edge=%0d got=%b exp=%b", e, bus.busy, (e >= 3 && e <= 5));
      end
    end
  endtask

  task automatic test_clean_fall();
    bus.a = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (bus.y !== (e < 6)) begin
        miscompares++;
        $display("FAIL fall_y edge=%0d got=%b exp=%b", e, bus.y, (e < 6));
      end
      vectors++;
      if (bus.busy !== (e >= 3 && e <= 5)) begin
        miscompares++;
        $display("FAIL fall_busy edge=%0d got=%b exp=%b", e, bus.busy, (e >= 3 && e <= 5));
      end
    end
  endtask

  // a high for three sampled edges, then low: never long enough to commit.
  task automatic test_glitch();
    bus.a = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) bus.a = 1'b0;
      vectors++;
      if (bus.y !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_y edge=%0d got=%b exp=0", e, bus.y);
      end
      vectors++;
      if (bus.busy !== (e >= 3 && e <= 5)) begin
        miscompares++;
        $display("FAIL glitch_busy edge=%0d got=%b exp=%b", e, bus.busy, (e >= 3 && e <= 5));
      end
    end
  endtask

  // a sampled 1,0,1,0,1 at edges 1..5 then held 1; last rise seen at edge 5.
  task automatic test_bounce();
    logic exp_busy;
    for (int e = 1; e <= 12; e++) begin
      bus.a = (e <= 5) ? ((e % 2) == 1) : 1'b1;
      tick();
      exp_busy = (e == 3) || (e == 5) || (e >= 7 && e <= 9);
      vectors++;
      if (bus.y !== (e >= 10)) begin
        miscompares++;
        $display("FAIL bounce_y edge=%0d got=%b exp=%b", e, bus.y, (e >= 10));
      end
      vectors++;
      if (bus.busy !== exp_busy) begin
        miscompares++;
        $display("FAIL bounce_busy edge=%0d got=%b exp=%b", e, bus.busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    bus.a = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before got=%b exp=1", bus.busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.y !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async got y=%b busy=%b exp y=0 busy=0", bus.y, bus.busy);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++;
      if (bus.busy !== 1'b0 || bus.y !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_hold cyc=%0d got y=%b busy=%b exp y=0 busy=0", c, bus.y, bus.busy);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (bus.y !== (e >= 6)) begin
        miscompares++;
        $display("FAIL midrst_y edge=%0d got=%b exp=%b", e, bus.y, (e >= 6));
      end
      vectors++;
      if (bus.busy !== (e >= 3 && e <= 5)) begin
        miscompares++;
        $display("FAIL midrst_busy edge=%0d got=%b exp=%b", e, bus.busy, (e >= 3 && e <= 5));
      end
    end
  endtask

  task automatic test_min_debounce();
    vectors++;
    if (bus1.y !== 1'b1) begin
      miscompares++;
      $display("FAIL min_y_reset got=%b exp=1", bus1.y);
    end
    rst1   = 1'b0;
    bus1.a = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (bus1.y !== (e < 3)) begin
        miscompares++;
        $display("FAIL min_y edge=%0d got=%b exp=%b", e, bus1.y, (e < 3));
      end
      vectors++;
      if (bus1.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL min_busy edge=%0d got=%b exp=0", e, bus1.busy);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rst1        = 1'b1;
    bus.a       = 1'b0;
    bus1.a      = 1'b1;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_clean_fall();
    test_reset_mid_count();
    test_min_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_debouncer.md
# sync_debouncer

Conditions a raw asynchronous level input (button, comparator, external trigger) into a clean, glitch-free, clock-domain-synchronous level. It sits directly upstream of the edge detector, which turns this block's output into one-cycle pulses. The block uses a multi-flop synchronizer followed by a counter-based debounce state machine. The output changes only after the synchronized input has held a new value for a programmable number of consecutive clock cycles.

## Interface
- SYNC_STAGES, default 2: number of synchronizer flops; legal range ≥ 2.
- DEBOUNCE_CYCLES, default 1000: consecutive differing samples required before `y` changes; legal range ≥ 1.
- RESET_LEVEL, default 1'b0: value loaded into the synchronizer flops and `y` on reset.
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- a  input  1  raw asynchronous input level.
- y  output  1  debounced, synchronous level; registered.
- busy  output  1  high while a candidate change is being qualified; registered.

## Operation
- **Synchronizer:** a chain of SYNC_STAGES flops; `a` feeds the first flop. `s` is the last stage. No logic is allowed between stages.
- **Counter:** `cnt`, width max(1, $clog2(DEBOUNCE_CYCLES)), unsigned.
- **State machine:** two states, STABLE and COUNT; `busy` = (state == COUNT).
- Each clock edge:
  - If `s == y`: `cnt` <= 0, state <= STABLE. An aborted candidate discards all progress.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `y` <= `s`, `cnt` <= 0, state <= STABLE.
  - Else: `cnt` <= `cnt`+1, state <= COUNT.
- **DEBOUNCE_CYCLES = 1:** `y` copies `s` one edge after `s` differs. State never enters COUNT and `busy` stays 0.
- **Counter range:** `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- **Symmetry:** rising and falling transitions are qualified identically.
- **Reset (asserted at any time, including mid-count):**
  - All synchronizer flops and `y` = RESET_LEVEL.
  - `cnt` = 0, state = STABLE, `busy` = 0.
  - Any candidate change is discarded.
- **Reset release:** normal operation resumes on the first rising edge after `rst` deasserts. If `a` differs from RESET_LEVEL at release, it is qualified as a normal change with full latency.

## Timing
- **Latency:** `a` stable at a new value from before edge 1 → `s` updates at edge SYNC_STAGES → `y` updates at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- **`busy`:** rises at edge SYNC_STAGES+1 when DEBOUNCE_CYCLES ≥ 2, and falls in the same edge that `y` updates.
- **Glitch rejection:** a pulse on `s` lasting fewer than DEBOUNCE_CYCLES cycles never reaches `y`. `busy` returns to 0 one edge after `s` reverts.
- **Reset outputs:** `y` = RESET_LEVEL and `busy` = 0 asynchronously with `rst` assertion, with no clock required.
- **Output stability:** `y` changes at most once per DEBOUNCE_CYCLES cycles, and is driven directly from a flop with no combinational path from `a`.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless noted otherwise.
- **Clean rise:** reset, release, `a`=1 before edge 1 and held → `y`=0 through edge 5, `y`=1 after edge 6; `busy` high after edges 3–5, low after edge 6.
- **Glitch rejection:** `a`=1 for 3 cycles then 0 → `y` stays 0 throughout; `busy` pulses for 3 cycles then returns to 0.
- **Bounce then settle:** `a` toggles 1,0,1,0,1 each cycle, then holds 1 → `y` rises exactly 6 edges after the final 0→1 transition, with no earlier change.
- **Clean fall:** `y`=1, `a`=0 held → `y`=0 after edge 6, mirroring the rise case.
- **Reset mid-count:** `y`=0, `a`=1, assert `rst` after edge 4 (`cnt`=2) for 2 cycles, then release with `a`=1 → `y`=0 and `busy`=0 during reset; after release, `y` rises 6 edges later (full requalification).
- **Minimum-debounce configuration:** DEBOUNCE_CYCLES=1, RESET_LEVEL=1 → `y`=1 out of reset; `a`=0 before edge 1 gives `y`=0 after edge 3; `busy` never asserts.
